// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//
// Purpose : Shared constants for the bit-serial adder. These are the FSM state
//           encoding (kept as plain two-bit localparams so older tools and
//           netlists can use it) and the legal range of the operand width.
// Ports   : none (package)
// Options : SERIAL_ADDER_OVF_EN is a macro used by serial_adder, not by this
//           package.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Legal operand width range
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

  // Width of the bit counter. It must be able to reach WIDTH itself, which
  // happens on the final ADD edge, so the count never wraps.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// Purpose : Single-bit combinational full adder. This is the bit slice that
//           serial_adder feeds one bit pair per clock.
// Ports   : a    - addend bit A
//           b    - addend bit B
//           cin  - carry in
//           s    - sum bit, a ^ b ^ cin
//           cout - carry out, majority(a, b, cin)
// -----------------------------------------------------------------------------
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_p;

  // Propagate term, shared by the sum and carry equations
  assign w_p  = a ^ b;
  assign s    = w_p ^ cin;
  assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Purpose : Bit-serial adder. A start pulse in IDLE loads two WIDTH-bit
//           operands and a carry-in. The operands are then passed LSB first
//           through one full_adder slice, one bit per clock, with the carry
//           held in a flop between bits. The finished result appears as a
//           registered sum/cout, and done pulses for one cycle.
//           {cout, sum} = a + b + cin (unsigned, exact).
//
// Parameters : WIDTH - operand/sum width, 1..32 (elaboration error otherwise)
//
// Ports   : clk   - clock, all state changes on the rising edge
//           rst_n - synchronous active-low reset
//           start - request; honoured only in IDLE
//           a, b  - operands, sampled on the accepting edge
//           cin   - carry in, sampled on the accepting edge
//           busy  - high while bits are being added (ADD)
//           done  - one-cycle pulse when a new result is valid (DONE)
//           sum   - registered result, held until the next result lands
//           cout  - registered carry out, held with sum
//           ovf   - (only with SERIAL_ADDER_OVF_EN) signed two's-complement
//                   overflow of the registered result, held with sum
//
// Build option : define SERIAL_ADDER_OVF_EN to add the ovf output.
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  // Reject illegal widths at elaboration
  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("serial_adder: WIDTH=%0d outside legal range %0d..%0d",
             WIDTH, WIDTH_MIN, WIDTH_MAX);
    end
  endgenerate

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  logic             w_fa_s;
  logic             w_fa_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_s_next;

  // Shift a vector right by one and insert a bit at the MSB. This is written
  // as a function so that WIDTH=1 works: a part-select [WIDTH-1:1] would be
  // reversed at that width.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v,
                                                input logic             msb);
    logic [WIDTH-1:0] r;
    r            = v >> 1;
    r[WIDTH-1]   = msb;
    return r;
  endfunction

  full_adder u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry),
    .s    (w_fa_s),
    .cout (w_fa_cout)
  );

  // The sum shift register fills from the top, so after WIDTH bits the
  // first (LSB) sum bit has moved down to bit 0.
  assign w_s_next = shift_in(r_s_sh, w_fa_s);

  // The bit at count WIDTH-1 is the MSB. For WIDTH=1 this is count 0.
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= ST_ADD;
          end
        end

        ST_ADD: begin
          r_s_sh  <= w_s_next;
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_carry <= w_fa_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum   <= w_s_next;
            r_cout  <= w_fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // On the MSB bit, r_carry is the carry into the MSB.
            r_ovf   <= r_carry ^ w_fa_cout;
`endif
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Always return to IDLE. A start seen here is dropped.
          r_state <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == ST_ADD);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Drives three serial_adder instances (WIDTH = 8, 3, 1). Each accepted
// request pushes its expected result into a per-instance queue. The expected
// result comes from plain integer arithmetic on a + b + cin. A negedge
// monitor checks busy/done/sum/cout (and ovf when SERIAL_ADDER_OVF_EN is
// defined) against the head of each queue.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  typedef struct {
    int         acc;   // edge number on which the request was accepted
    logic [7:0] s;
    logic       co;
    logic       ov;
    logic [7:0] ps;    // result visible while this operation is in flight
    logic       pco;
    logic       pov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc = 0;
  logic       mon_en = 1'b0;

  logic       st [3];
  logic [7:0] av [3];
  logic [7:0] bv [3];
  logic       cv [3];

  logic       busy_w [3];
  logic       done_w [3];
  logic       cout_w [3];
  logic [7:0] sum8;
  logic [2:0] sum3;
  logic [0:0] sum1;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf_w [3];
`endif

  exp_t       q [3][$];
  logic [7:0] cur_s  [3];
  logic       cur_co [3];
  logic       cur_ov [3];
  int         free_at [3];

  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0]), .b(bv[0]), .cin(cv[0]),
    .busy(busy_w[0]), .done(done_w[0]), .sum(sum8), .cout(cout_w[0])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf_w[0])
`endif
  );

  serial_adder #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1][2:0]), .b(bv[1][2:0]), .cin(cv[1]),
    .busy(busy_w[1]), .done(done_w[1]), .sum(sum3), .cout(cout_w[1])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf_w[1])
`endif
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2][0:0]), .b(bv[2][0:0]), .cin(cv[2]),
    .busy(busy_w[2]), .done(done_w[2]), .sum(sum1), .cout(cout_w[2])
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf_w[2])
`endif
  );

  function automatic int wof(input int i);
    case (i)
      0:       return 8;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic logic [7:0] sum_of(input int i);
    case (i)
      0:       return sum8;
      1:       return {5'd0, sum3};
      default: return {7'd0, sum1};
    endcase
  endfunction

  // Reference: unsigned total gives sum/cout; signed total gives overflow.
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic c);
    exp_t e;
    int   mask, ai, bi, tot, sa, sb, ss;
    mask = (1 << w) - 1;
    ai   = int'(a) & mask;
    bi   = int'(b) & mask;
    tot  = ai + bi + int'(c);
    sa   = (ai >= (1 << (w - 1))) ? ai - (1 << w) : ai;
    sb   = (bi >= (1 << (w - 1))) ? bi - (1 << w) : bi;
    ss   = sa + sb + int'(c);
    e.acc = 0;
    e.s   = 8'(tot & mask);
    e.co  = ((tot >> w) & 1) != 0;
    e.ov  = (ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)));
    e.ps  = 8'd0;
    e.pco = 1'b0;
    e.pov = 1'b0;
    return e;
  endfunction

  // Advance one clock and record what each DUT did with the inputs held
  // across that edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        q[i].delete();
        cur_s[i]   = 8'd0;
        cur_co[i]  = 1'b0;
        cur_ov[i]  = 1'b0;
        free_at[i] = cyc + 1;
      end else if (st[i] && cyc >= free_at[i]) begin
        e     = model(wof(i), av[i], bv[i], cv[i]);
        e.acc = cyc;
        e.ps  = cur_s[i];
        e.pco = cur_co[i];
        e.pov = cur_ov[i];
        q[i].push_back(e);
        cur_s[i]   = e.s;
        cur_co[i]  = e.co;
        cur_ov[i]  = e.ov;
        free_at[i] = cyc + wof(i) + 2;
      end
    end
  endtask

  // One request on an idle DUT. Operands are scrambled after acceptance,
  // and the task waits until the DUT is idle again.
  task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic c);
    st[i] = 1'b1;
    av[i] = a;
    bv[i] = b;
    cv[i] = c;
    step();
    st[i] = 1'b0;
    av[i] = ~a;
    bv[i] = 8'($urandom);
    cv[i] = ~c;
    repeat (wof(i) + 1) step();
  endtask

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d: got %0h, expected %0h", nm, i, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic       exp_busy;
    logic [7:0] vis_s;
    logic       vis_co;
    logic       vis_ov;
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        if (q[i].size() > 0 && cyc == q[i][0].acc + wof(i)) begin
          chk("done_pulse", i, 32'(done_w[i]), 32'd1);
          chk("busy_in_done", i, 32'(busy_w[i]), 32'd0);
          chk("sum", i, 32'(sum_of(i)), 32'(q[i][0].s));
          chk("cout", i, 32'(cout_w[i]), 32'(q[i][0].co));
`ifdef SERIAL_ADDER_OVF_EN
          chk("ovf", i, 32'(ovf_w[i]), 32'(q[i][0].ov));
`endif
          void'(q[i].pop_front());
        end else begin
          exp_busy = (q[i].size() > 0) && (cyc >= q[i][0].acc) &&
                     (cyc < q[i][0].acc + wof(i));
          vis_s  = (q[i].size() > 0) ? q[i][0].ps  : cur_s[i];
          vis_co = (q[i].size() > 0) ? q[i][0].pco : cur_co[i];
          vis_ov = (q[i].size() > 0) ? q[i][0].pov : cur_ov[i];
          chk("done_quiet", i, 32'(done_w[i]), 32'd0);
          chk("busy", i, 32'(busy_w[i]), 32'(exp_busy));
          chk("sum_held", i, 32'(sum_of(i)), 32'(vis_s));
          chk("cout_held", i, 32'(cout_w[i]), 32'(vis_co));
`ifdef SERIAL_ADDER_OVF_EN
          chk("ovf_held", i, 32'(ovf_w[i]), 32'(vis_ov));
`else
          if (vis_ov === 1'bx) n_tests = n_tests + 0;
`endif
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; av[i] = 8'd0; bv[i] = 8'd0; cv[i] = 1'b0;
      cur_s[i] = 8'd0; cur_co[i] = 1'b0; cur_ov[i] = 1'b0; free_at[i] = 0;
    end

    // Reset, then check the reset state from the monitor
    rst_n = 1'b0;
    step();
    step();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();

    // Directed sums on the 8-bit instance
    run_op(0, 8'h5A, 8'h3C, 1'b0);
    run_op(0, 8'hFF, 8'h01, 1'b0);
    run_op(0, 8'hFF, 8'hFF, 1'b1);

    // start toggled during ADD/DONE with zeroed operands must be ignored
    st[0] = 1'b1; av[0] = 8'h21; bv[0] = 8'h43; cv[0] = 1'b1;
    step();
    for (int k = 0; k < 9; k++) begin
      st[0] = (k % 2 == 0);
      av[0] = 8'h00;
      bv[0] = 8'h00;
      step();
    end
    st[0] = 1'b0;
    step();

    // Reset during the 4th ADD cycle aborts the operation with no done
    st[0] = 1'b1; av[0] = 8'hC3; bv[0] = 8'h5F; cv[0] = 1'b1;
    step();
    st[0] = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (12) step();
    run_op(0, 8'h12, 8'h34, 1'b1);

    // start held high: back-to-back operations, operands changing every cycle
    st[0] = 1'b1;
    repeat (30) begin
      av[0] = 8'($urandom);
      bv[0] = 8'($urandom);
      cv[0] = 1'($urandom);
      step();
    end
    st[0] = 1'b0;
    repeat (12) step();

    // Random operands
    repeat (40) run_op(0, 8'($urandom), 8'($urandom), 1'($urandom));

    // Signed-overflow corner values
    run_op(0, 8'h7F, 8'h01, 1'b0);
    run_op(0, 8'h80, 8'h80, 1'b0);
    run_op(0, 8'h40, 8'h20, 1'b0);

    // Exhaustive over the narrow instances
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        for (int c = 0; c < 2; c++)
          run_op(1, 8'(x), 8'(y), 1'(c));
    for (int x = 0; x < 2; x++)
      for (int y = 0; y < 2; y++)
        for (int c = 0; c < 2; c++)
          run_op(2, 8'(x), 8'(y), 1'(c));

    repeat (12) step();
    for (int i = 0; i < 3; i++) begin
      if (q[i].size() != 0) begin
        $display("FAIL pending dut%0d: got %0d results outstanding, expected 0", i, q[i].size());
        $fatal(1, "outstanding results");
      end
    end
    mon_en = 1'b0;
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
